reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter N_OUT, default 3: number of sequenced reset outputs; legal range 1..8.
REQ-002 Parameter LOCK_FILT, default 8: consecutive cycles the synchronised lock must stay high before sequencing; legal range >=1.
REQ-003 Parameter GAP, default 16: clk cycles between successive output releases; legal range >=1.
REQ-004 Port clk, input, 1: sequencer clock.
REQ-005 Port resetn, input, 1: reset, asynchronous, active-low.
REQ-006 Port pll_lock, input, 1: PLL lock; asynchronous to clk.
REQ-007 Port soft_rst, input, 1: synchronous re-sequence request, active-high.
REQ-008 Port rst_n_out, output, N_OUT: active-low domain resets; bit 0 is released first.
REQ-009 Port seq_done, output, 1: high while every rst_n_out bit is released.
REQ-010 Port state_o, output, 2: current state; HOLD=0, FILTER=1, RELEASE=2, RUN=3.
REQ-011 Port lock_lost, output, 1: sticky lock-loss flag (see Configuration).

Function
REQ-012 pll_lock SHALL pass through a 2-flop synchroniser (lock_s); T0 is the first clk edge where lock_s samples high.
REQ-013 HOLD: all rst_n_out = 0; when lock_s = 1 and soft_rst = 0, go to FILTER with filter count = 0.
REQ-014 FILTER: filter count increments each cycle while lock_s = 1; lock_s = 0 returns to HOLD; at count LOCK_FILT-1, go to RELEASE with stage = 0 and gap count = 0.
REQ-015 RELEASE: gap count increments each cycle; at GAP-1, set rst_n_out[stage] = 1, increment stage and clear gap count; releasing bit N_OUT-1 goes to RUN.
REQ-016 Release timing: rst_n_out[k] SHALL rise at T0+LOCK_FILT+(k+1)*GAP.
REQ-017 Released bits SHALL stay high through the rest of RELEASE; bits are never released out of order.
REQ-018 seq_done SHALL be 1 only in RUN and SHALL rise in the same cycle as rst_n_out[N_OUT-1].
REQ-019 Abort: lock_s = 0 or soft_rst = 1 in FILTER, RELEASE or RUN → next edge enters HOLD, all rst_n_out = 0, seq_done = 0, counters and stage cleared.
REQ-020 Simultaneous abort and release in the same cycle: abort wins; the output stays 0.
REQ-021 soft_rst held high keeps the block in HOLD; sequencing restarts from FILTER once soft_rst = 0 and lock_s = 1.
REQ-022 A one-cycle soft_rst pulse SHALL trigger a full re-sequence.
REQ-023 Counters SHALL be sized to hold max(LOCK_FILT, GAP)-1 without wrap; stage is $clog2(N_OUT+1) bits.

Reset
REQ-024 resetn low SHALL asynchronously force rst_n_out = 0, seq_done = 0, state HOLD, lock_lost = 0 and all counters and synchroniser flops to 0.
REQ-025 resetn deassertion SHALL take effect synchronously to clk.
REQ-026 No output rises within 2 cycles of resetn release.
REQ-027 resetn asserted mid-RELEASE SHALL clear all released bits immediately, without waiting for a clk edge.

Configuration
REQ-028 Macro RSTSEQ_LOCK_LOST_EN defined: lock_lost is set on the edge that leaves RUN because lock_s = 0, and is cleared only by resetn.
REQ-029 Macro RSTSEQ_LOCK_LOST_EN defined: soft_rst does not set lock_lost.
REQ-030 Macro RSTSEQ_LOCK_LOST_EN undefined: lock_lost is tied 0, no flag logic is built, and all other behaviour is identical.

Verification
REQ-031 Defaults, resetn released, pll_lock high → rst_n_out[0]/[1]/[2] rise at T0+24/T0+40/T0+56; seq_done rises at T0+56; state_o = 3.
REQ-032 pll_lock low for 1 cycle (lock_s low) at T0+5 → return to HOLD; a new T0 is taken and full timing restarts; no output rises before the new T0+24.
REQ-033 In RUN, 1-cycle soft_rst → next edge all rst_n_out = 0 and seq_done = 0; re-release at 24/40/56 cycles after the first edge with lock_s high in HOLD; lock_lost stays 0.
REQ-034 In RUN, pll_lock dropped → outputs 0 within 3 edges; lock_lost = 1 with macro, 0 without; lock_lost stays 1 after relock until resetn.
REQ-035 resetn pulsed low mid-RELEASE (after rst_n_out[0] = 1) → rst_n_out = 0 asynchronously before the next edge; state_o = 0.
REQ-036 N_OUT=1, LOCK_FILT=1, GAP=1 → rst_n_out[0] and seq_done rise at T0+2.

Source files
------------

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - PLL-lock qualified, staggered release of domain resets
//
// Waits for a filtered PLL lock, then releases N_OUT active-low domain resets
// one at a time, GAP clk cycles apart, bit 0 first. Loss of lock or a soft
// reset request drops every output at once and restarts the sequence.
//
// Optional feature macro: RSTSEQ_LOCK_LOST_EN
//   defined   - lock_lost is a sticky flag set when lock is lost while in RUN,
//               cleared only by resetn.
//   undefined - lock_lost is tied low and no flag logic is built.
//
// Parameters:
//   N_OUT      number of sequenced reset outputs (1..8)
//   LOCK_FILT  cycles the synchronised lock must stay high before sequencing (>=1)
//   GAP        clk cycles between successive releases (>=1)
//
// Ports:
//   clk        sequencer clock
//   resetn     asynchronous active-low reset, deassertion sampled by clk
//   pll_lock   PLL lock, asynchronous to clk
//   soft_rst   synchronous active-high re-sequence request
//   rst_n_out  active-low domain resets, bit 0 released first
//   seq_done   high while every rst_n_out bit is released
//   state_o    current state: HOLD=0, FILTER=1, RELEASE=2, RUN=3
//   lock_lost  sticky lock-loss flag (see macro above)

module reset_sequencer #(
    parameter int N_OUT     = 3,
    parameter int LOCK_FILT = 8,
    parameter int GAP       = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             pll_lock,
    input  logic             soft_rst,
    output logic [N_OUT-1:0] rst_n_out,
    output logic             seq_done,
    output logic [1:0]       state_o,
    output logic             lock_lost
);

    localparam logic [1:0] S_HOLD    = 2'd0;
    localparam logic [1:0] S_FILTER  = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;
    localparam logic [1:0] S_RUN     = 2'd3;

    // Counters must hold max(LOCK_FILT, GAP)-1 without wrapping.
    localparam int MAX_CNT = (LOCK_FILT > GAP) ? LOCK_FILT : GAP;
    localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam int SW      = $clog2(N_OUT + 1);

    localparam logic [CW-1:0] FILT_LAST  = CW'(LOCK_FILT - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP - 1);
    localparam logic [SW-1:0] STAGE_LAST = SW'(N_OUT - 1);

    // Two-flop synchroniser for the asynchronous lock input.
    logic             r_sync1;
    logic             r_lock_s;

    logic [1:0]       r_state;
    logic [CW-1:0]    r_fcnt;
    logic [CW-1:0]    r_gcnt;
    logic [SW-1:0]    r_stage;
    logic [N_OUT-1:0] r_rst_n;

    logic [1:0]       w_state;
    logic [CW-1:0]    w_fcnt;
    logic [CW-1:0]    w_gcnt;
    logic [SW-1:0]    w_stage;
    logic [N_OUT-1:0] w_rst_n;
    logic             w_abort;
    logic             w_step;
    logic [CW-1:0]    w_gap_base;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync1  <= 1'b0;
            r_lock_s <= 1'b0;
        end else begin
            r_sync1  <= pll_lock;
            r_lock_s <= r_sync1;
        end
    end

    assign w_abort = !r_lock_s || soft_rst;

    // The HOLD->FILTER edge already counts as the first filter cycle, so the
    // last filter cycle is also the first gap cycle: leaving FILTER runs one
    // gap step with a gap base of zero. This lines the first release up with
    // LOCK_FILT+GAP cycles after lock is seen, and lets GAP=1 release bit 0 on
    // the very edge that leaves FILTER.
    always_comb begin
        w_state    = r_state;
        w_fcnt     = r_fcnt;
        w_gcnt     = r_gcnt;
        w_stage    = r_stage;
        w_rst_n    = r_rst_n;
        w_step     = 1'b0;
        w_gap_base = r_gcnt;

        case (r_state)
            S_HOLD: begin
                w_rst_n = '0;
                w_fcnt  = '0;
                w_gcnt  = '0;
                w_stage = '0;
                if (r_lock_s && !soft_rst) begin
                    w_state = S_FILTER;
                end
            end
            S_FILTER: begin
                if (w_abort) begin
                    w_state = S_HOLD;
                    w_rst_n = '0;
                    w_fcnt  = '0;
                    w_gcnt  = '0;
                    w_stage = '0;
                end else if (r_fcnt == FILT_LAST) begin
                    w_step     = 1'b1;
                    w_gap_base = '0;
                    w_fcnt     = '0;
                end else begin
                    w_fcnt = r_fcnt + CW'(1);
                end
            end
            S_RELEASE: begin
                if (w_abort) begin
                    w_state = S_HOLD;
                    w_rst_n = '0;
                    w_fcnt  = '0;
                    w_gcnt  = '0;
                    w_stage = '0;
                end else begin
                    w_step = 1'b1;
                end
            end
            S_RUN: begin
                if (w_abort) begin
                    w_state = S_HOLD;
                    w_rst_n = '0;
                    w_fcnt  = '0;
                    w_gcnt  = '0;
                    w_stage = '0;
                end
            end
            default: begin
                w_state = S_HOLD;
                w_rst_n = '0;
                w_fcnt  = '0;
                w_gcnt  = '0;
                w_stage = '0;
            end
        endcase

        // Gap step: only reached when no abort is pending, so an abort in the
        // same cycle as a release always wins.
        if (w_step) begin
            if (w_gap_base == GAP_LAST) begin
                for (int k = 0; k < N_OUT; k++) begin
                    if (r_stage == SW'(k)) begin
                        w_rst_n[k] = 1'b1;
                    end
                end
                w_gcnt = '0;
                if (r_stage == STAGE_LAST) begin
                    w_state = S_RUN;
                end else begin
                    w_stage = r_stage + SW'(1);
                    w_state = S_RELEASE;
                end
            end else begin
                w_gcnt  = w_gap_base + CW'(1);
                w_state = S_RELEASE;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_HOLD;
            r_fcnt  <= '0;
            r_gcnt  <= '0;
            r_stage <= '0;
            r_rst_n <= '0;
        end else begin
            r_state <= w_state;
            r_fcnt  <= w_fcnt;
            r_gcnt  <= w_gcnt;
            r_stage <= w_stage;
            r_rst_n <= w_rst_n;
        end
    end

    assign rst_n_out = r_rst_n;
    assign seq_done  = (r_state == S_RUN);
    assign state_o   = r_state;

`ifdef RSTSEQ_LOCK_LOST_EN
    logic r_lock_lost;

    // Only a lock drop out of RUN sets the flag; soft_rst aborts do not.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_lock_lost <= 1'b0;
        end else if ((r_state == S_RUN) && !r_lock_s) begin
            r_lock_lost <= 1'b1;
        end
    end

    assign lock_lost = r_lock_lost;
`else
    assign lock_lost = 1'b0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - scoreboard bench for reset_sequencer

module tb_reset_sequencer;

    localparam int N_OUT = 3;
    localparam int LF    = 8;
    localparam int GAP   = 16;

    typedef struct {
        int idx;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             resetn     = 1'b0;
    logic             pll_lock   = 1'b0;
    logic             soft_rst   = 1'b0;
    logic             pll_lock_m = 1'b0;

    logic [N_OUT-1:0] rst_n_out;
    logic             seq_done;
    logic [1:0]       state_o;
    logic             lock_lost;

    logic [0:0]       rst_n_out_m;
    logic             seq_done_m;
    logic [1:0]       state_o_m;
    logic             lock_lost_m;

    reset_sequencer #(.N_OUT(N_OUT), .LOCK_FILT(LF), .GAP(GAP)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .pll_lock  (pll_lock),
        .soft_rst  (soft_rst),
        .rst_n_out (rst_n_out),
        .seq_done  (seq_done),
        .state_o   (state_o),
        .lock_lost (lock_lost)
    );

    reset_sequencer #(.N_OUT(1), .LOCK_FILT(1), .GAP(1)) dut_min (
        .clk       (clk),
        .resetn    (resetn),
        .pll_lock  (pll_lock_m),
        .soft_rst  (soft_rst),
        .rst_n_out (rst_n_out_m),
        .seq_done  (seq_done_m),
        .state_o   (state_o_m),
        .lock_lost (lock_lost_m)
    );

    int  cyc     = 0;
    int  n_check = 0;
    int  n_pass  = 0;
    ev_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_check++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic push_ev(input int idx, input int when);
        ev_t e;
        e.idx = idx;
        e.cyc = when;
        exp_q.push_back(e);
    endtask

    // Expected release edges for a sequence whose T0 is t0; index N_OUT is seq_done.
    task automatic push_seq(input int t0);
        for (int k = 0; k < N_OUT; k++) push_ev(k, t0 + LF + (k + 1) * GAP);
        push_ev(N_OUT, t0 + LF + N_OUT * GAP);
    endtask

    task automatic wait_empty(input int budget);
        int b;
        b = budget;
        while (exp_q.size() != 0 && b > 0) begin
            step();
            b--;
        end
        check("seq_timeout", exp_q.size(), 0);
    endtask

    // Rising-edge monitor: every rise of an output or seq_done must match the
    // head of the scoreboard in both index and cycle.
    logic [N_OUT:0] prev = '0;
    always @(negedge clk) begin
        logic [N_OUT:0] cur;
        ev_t e;
        cur = {seq_done, rst_n_out};
        for (int k = 0; k <= N_OUT; k++) begin
            if (cur[k] === 1'b1 && prev[k] !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rise", k, 99);
                end else begin
                    e = exp_q.pop_front();
                    check("rise_idx", k, e.idx);
                    check("rise_cyc", cyc, e.cyc);
                end
            end
        end
        prev = cur;
    end

    initial begin
        int   t0;
        int   b;
        logic exp_ll;
`ifdef RSTSEQ_LOCK_LOST_EN
        exp_ll = 1'b1;
`else
        exp_ll = 1'b0;
`endif

        // Reset state.
        repeat (3) step();
        check("rst_rst_n_out", rst_n_out, 0);
        check("rst_seq_done", seq_done, 0);
        check("rst_state", state_o, 0);
        check("rst_lock_lost", lock_lost, 0);
        check("rst_min_out", rst_n_out_m, 0);
        resetn = 1'b1;
        step();

        // Lock with a one-cycle glitch at T0+5: timing restarts from new T0.
        t0 = cyc + 2;
        pll_lock = 1'b1;
        while (cyc < t0 + 3) step();
        pll_lock = 1'b0;
        step();
        pll_lock = 1'b1;
        step();
        step();
        check("glitch_hold", state_o, 0);
        push_seq(t0 + 6);
        wait_empty(150);
        check("run_state", state_o, 3);
        check("run_done", seq_done, 1);
        check("run_outs", rst_n_out, 3'b111);
        check("run_lock_lost", lock_lost, 0);

        // One-cycle soft_rst in RUN.
        soft_rst = 1'b1;
        step();
        soft_rst = 1'b0;
        check("soft_outs", rst_n_out, 0);
        check("soft_done", seq_done, 0);
        check("soft_state", state_o, 0);
        push_seq(cyc);
        wait_empty(150);
        check("soft_run_state", state_o, 3);
        check("soft_lock_lost", lock_lost, 0);

        // Lock drop in RUN, then relock.
        pll_lock = 1'b0;
        repeat (3) step();
        check("drop_outs", rst_n_out, 0);
        check("drop_done", seq_done, 0);
        check("drop_state", state_o, 0);
        check("drop_lock_lost", lock_lost, exp_ll);
        pll_lock = 1'b1;
        t0 = cyc + 2;
        push_ev(0, t0 + LF + GAP);
        wait_empty(100);
        check("relock_lock_lost", lock_lost, exp_ll);

        // soft_rst lands on the bit-1 release edge: abort wins.
        while (cyc < t0 + LF + 2 * GAP - 1) step();
        soft_rst = 1'b1;
        step();
        soft_rst = 1'b0;
        check("abort_wins_outs", rst_n_out, 0);
        check("abort_wins_state", state_o, 0);
        check("abort_lock_lost", lock_lost, exp_ll);
        push_seq(cyc);

        // Async resetn mid-RELEASE once bit 0 is out.
        b = 100;
        while (exp_q.size() == N_OUT + 1 && b > 0) begin
            step();
            b--;
        end
        check("bit0_timeout", (exp_q.size() == N_OUT) ? 1 : 0, 1);
        step();
        step();
        resetn = 1'b0;
        #1;
        check("async_outs", rst_n_out, 0);
        check("async_state", state_o, 0);
        check("async_done", seq_done, 0);
        check("async_lock_lost", lock_lost, 0);
        exp_q.delete();
        step();
        resetn = 1'b1;
        t0 = cyc + 2;
        push_seq(t0);
        wait_empty(150);
        check("post_reset_state", state_o, 3);

        // Minimum configuration: N_OUT=1, LOCK_FILT=1, GAP=1.
        pll_lock_m = 1'b1;
        t0 = cyc + 2;
        while (cyc < t0 + 1) step();
        check("min_early_out", rst_n_out_m, 0);
        check("min_early_done", seq_done_m, 0);
        step();
        check("min_out", rst_n_out_m, 1);
        check("min_done", seq_done_m, 1);
        check("min_state", state_o_m, 3);

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
